// File: rtl/throw_hit_sequencer.sv
// Throw button front end: synchronizes and debounces the active-low button, then emits one
// spaced hit pulse per knocked pin. Optional STRIKE_FLAG_EN adds a one-cycle strike output.
module throw_hit_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HIT_GAP         = 4,
    parameter int MAX_THROWS      = 3
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       throw_btn_n,
    input  logic [3:0] pins_in,
    output logic       hit,
    output logic       busy,
    output logic [1:0] throw_num,
`ifdef STRIKE_FLAG_EN
    output logic       strike,
`endif
    output logic       game_over
);

    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int GW  = (HIT_GAP > 1) ? $clog2(HIT_GAP) : 1;
    localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [GW-1:0]  GAP_LOAD   = GW'(HIT_GAP - 1);
    localparam logic [1:0]     THROW_LAST = 2'(MAX_THROWS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EMIT,
        S_GAP,
        S_FINISH
    } state_t;

    logic [1:0]     sync_reg;
    logic           db_level_reg;
    logic [DBW-1:0] db_cnt_reg;
    logic           btn_sync;
    logic           level_differs;
    logic           db_flip;
    logic           press_accept;

    state_t         state_reg, state_next;
    logic [3:0]     burst_reg, burst_next;
    logic [GW-1:0]  gap_reg, gap_next;
    logic [1:0]     throw_reg, throw_next;
    logic           game_over_reg, game_over_next;
    logic           hit_reg, hit_next;
    logic           busy_reg, busy_next;

    // Two-flop synchronizer; idles at the released level.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], throw_btn_n};
        end
    end

    assign btn_sync      = sync_reg[1];
    assign level_differs = (btn_sync != db_level_reg);
    assign db_flip       = level_differs && (db_cnt_reg == DB_LAST);
    assign press_accept  = db_flip && !btn_sync;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            db_level_reg <= 1'b1;
            db_cnt_reg   <= '0;
        end else if (db_flip) begin
            db_level_reg <= btn_sync;
            db_cnt_reg   <= '0;
        end else if (level_differs) begin
            db_cnt_reg   <= db_cnt_reg + 1'b1;
        end else begin
            db_cnt_reg   <= '0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            burst_reg     <= '0;
            gap_reg       <= '0;
            throw_reg     <= '0;
            game_over_reg <= 1'b0;
            hit_reg       <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            burst_reg     <= burst_next;
            gap_reg       <= gap_next;
            throw_reg     <= throw_next;
            game_over_reg <= game_over_next;
            hit_reg       <= hit_next;
            busy_reg      <= busy_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        burst_next     = burst_reg;
        gap_next       = gap_reg;
        throw_next     = throw_reg;
        game_over_next = game_over_reg;
        case (state_reg)
            S_IDLE: begin
                if (press_accept && !game_over_reg) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                burst_next = (pins_in > 4'd10) ? 4'd10 : pins_in;
                state_next = (burst_next == 4'd0) ? S_FINISH : S_EMIT;
            end
            S_EMIT: begin
                burst_next = burst_reg - 4'd1;
                if (burst_next == 4'd0) begin
                    state_next = S_FINISH;
                end else begin
                    state_next = S_GAP;
                    gap_next   = GAP_LOAD;
                end
            end
            S_GAP: begin
                if (gap_reg == '0) begin
                    state_next = S_EMIT;
                end else begin
                    gap_next = gap_reg - 1'b1;
                end
            end
            S_FINISH: begin
                if (throw_reg < THROW_LAST) begin
                    throw_next = throw_reg + 2'd1;
                end
                if (throw_next == THROW_LAST) begin
                    game_over_next = 1'b1;
                end
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    assign hit_next  = (state_next == S_EMIT);
    assign busy_next = (state_next == S_LOAD) || (state_next == S_EMIT) || (state_next == S_GAP);

    assign hit       = hit_reg;
    assign busy      = busy_reg;
    assign throw_num = throw_reg;
    assign game_over = game_over_reg;

`ifdef STRIKE_FLAG_EN
    logic strike_lat_reg, strike_lat_next;
    logic strike_reg, strike_next;

    always_comb begin
        strike_lat_next = strike_lat_reg;
        if (state_reg == S_LOAD) begin
            strike_lat_next = (pins_in >= 4'd10);
        end
        strike_next = (state_next == S_FINISH) && strike_lat_next;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            strike_lat_reg <= 1'b0;
            strike_reg     <= 1'b0;
        end else begin
            strike_lat_reg <= strike_lat_next;
            strike_reg     <= strike_next;
        end
    end

    assign strike = strike_reg;
`endif

endmodule

// File: tb/tb_throw_hit_sequencer.sv
// Directed bench for throw_hit_sequencer with a short debounce window (8 cycles).
module tb_throw_hit_sequencer;

    logic       CLOCK_50    = 1'b0;
    logic       reset_n     = 1'b0;
    logic       throw_btn_n = 1'b1;
    logic [3:0] pins_in     = 4'd0;
    logic       hit;
    logic       busy;
    logic [1:0] throw_num;
    logic       game_over;
`ifdef STRIKE_FLAG_EN
    logic       strike;
    int         strike_total = 0;
`endif

    throw_hit_sequencer #(
        .DEBOUNCE_CYCLES(8),
        .HIT_GAP        (4),
        .MAX_THROWS     (3)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .throw_btn_n(throw_btn_n),
        .pins_in    (pins_in),
        .hit        (hit),
        .busy       (busy),
        .throw_num  (throw_num),
`ifdef STRIKE_FLAG_EN
        .strike     (strike),
`endif
        .game_over  (game_over)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc          = 0;
    int   hit_total    = 0;
    int   busy_total   = 0;
    int   consec_total = 0;
    int   hit_times[$];
    logic prev_hit     = 1'b0;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    always @(negedge CLOCK_50) begin
        if (hit) begin
            hit_total <= hit_total + 1;
            hit_times.push_back(cyc);
            if (prev_hit) consec_total <= consec_total + 1;
        end
        busy_total <= busy_total + int'(busy);
        prev_hit   <= hit;
`ifdef STRIKE_FLAG_EN
        if (strike) strike_total <= strike_total + 1;
`endif
    end

    task automatic check_val(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0d", tag, got);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic press(input int pins, input int hold);
        pins_in     = 4'(pins);
        throw_btn_n = 1'b0;
        cycles(hold);
        throw_btn_n = 1'b1;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        throw_btn_n = 1'b1;
        cycles(3);
        reset_n     = 1'b1;
        cycles(2);
    endtask

    int h0, b0, n0;

    initial begin
        cycles(2);
        check_val("reset_hit", int'(hit), 0);
        check_val("reset_busy", int'(busy), 0);
        check_val("reset_throw_num", int'(throw_num), 0);
        check_val("reset_game_over", int'(game_over), 0);
        reset_n = 1'b1;
        cycles(2);

        // 1: bouncing button never settles long enough
        h0 = hit_total; b0 = busy_total;
        for (int i = 0; i < 14; i++) begin
            throw_btn_n = ~throw_btn_n;
            cycles(3);
        end
        throw_btn_n = 1'b1;
        cycles(30);
        check_val("bounce_hits", hit_total - h0, 0);
        check_val("bounce_busy", busy_total - b0, 0);
        check_val("bounce_throw_num", int'(throw_num), 0);

        // 2: three pins, hits 5 cycles apart, busy for 12 cycles
        do_reset();
        h0 = hit_total; b0 = busy_total; n0 = hit_times.size();
        press(3, 20);
        cycles(60);
        check_val("burst3_hits", hit_total - h0, 3);
        if (hit_times.size() >= n0 + 3) begin
            check_val("burst3_gap1", hit_times[n0+1] - hit_times[n0], 5);
            check_val("burst3_gap2", hit_times[n0+2] - hit_times[n0], 10);
        end else begin
            check_val("burst3_logged", hit_times.size() - n0, 3);
        end
        check_val("burst3_busy", busy_total - b0, 12);
        check_val("burst3_throw_num", int'(throw_num), 1);
        check_val("burst3_game_over", int'(game_over), 0);

        // 3: clamp 15 -> 10, then a zero-pin throw
        do_reset();
        h0 = hit_total;
        press(15, 20);
        cycles(70);
        check_val("clamp_hits", hit_total - h0, 10);
        check_val("clamp_throw_num", int'(throw_num), 1);
        h0 = hit_total; b0 = busy_total;
        press(0, 20);
        cycles(40);
        check_val("zero_hits", hit_total - h0, 0);
        check_val("zero_busy", busy_total - b0, 1);
        check_val("zero_throw_num", int'(throw_num), 2);

        // 4: three full throws end the game; a fourth is ignored
        do_reset();
        h0 = hit_total;
        for (int i = 0; i < 3; i++) begin
            press(10, 20);
            cycles(70);
            if (i == 1) check_val("game_not_over_yet", int'(game_over), 0);
        end
        check_val("game_hits", hit_total - h0, 30);
        check_val("game_throw_num", int'(throw_num), 3);
        check_val("game_over_set", int'(game_over), 1);
        h0 = hit_total; b0 = busy_total;
        press(10, 20);
        cycles(70);
        check_val("over_hits", hit_total - h0, 0);
        check_val("over_busy", busy_total - b0, 0);
        check_val("over_throw_num", int'(throw_num), 3);
        check_val("over_sticky", int'(game_over), 1);

        // 5: a second debounced press lands mid-burst and is dropped
        do_reset();
        h0 = hit_total; b0 = busy_total;
        pins_in = 4'd5;
        throw_btn_n = 1'b0; cycles(9);
        throw_btn_n = 1'b1; cycles(9);
        throw_btn_n = 1'b0; cycles(9);
        throw_btn_n = 1'b1;
        cycles(60);
        check_val("busy_press_hits", hit_total - h0, 5);
        check_val("busy_press_busy", busy_total - b0, 22);
        check_val("busy_press_throw_num", int'(throw_num), 1);

        // 6: reset after the second hit of a 7-pin burst
        do_reset();
        h0 = hit_total;
        pins_in = 4'd7;
        throw_btn_n = 1'b0;
        for (int i = 0; i < 100 && hit_total < h0 + 2; i++) cycles(1);
        check_val("abort_second_hit_seen", hit_total - h0, 2);
        reset_n = 1'b0;
        throw_btn_n = 1'b1;
        #1;
        check_val("abort_hit", int'(hit), 0);
        check_val("abort_busy", int'(busy), 0);
        check_val("abort_throw_num", int'(throw_num), 0);
        cycles(3);
        reset_n = 1'b1;
        cycles(20);
        h0 = hit_total;
`ifdef STRIKE_FLAG_EN
        b0 = strike_total;
        press(10, 20);
        cycles(70);
        check_val("after_abort_hits", hit_total - h0, 10);
        check_val("strike_pulses", strike_total - b0, 1);
`else
        press(2, 20);
        cycles(40);
        check_val("after_abort_hits", hit_total - h0, 2);
`endif
        check_val("after_abort_throw_num", int'(throw_num), 1);
        check_val("no_back_to_back_hits", consec_total, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
